// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// The DM bundle keeps slot 0 in its most significant field.
package rf_arb_pkg;

   localparam int AW       = 4;
   localparam int DW       = 16;
   localparam int DM_SLOTS = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DM0  = 2'd1;
   localparam logic [1:0] ST_DM1  = 2'd2;

   // Slot-to-port map: phase 0 fills M/A/S, phase 1 fills M/A.
   localparam int PH0_SLOT_M = 0;
   localparam int PH0_SLOT_A = 1;
   localparam int PH0_SLOT_S = 2;
   localparam int PH1_SLOT_M = 3;
   localparam int PH1_SLOT_A = 4;

   typedef struct packed {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_port_t;

   function automatic logic [AW-1:0] slot_addr(input logic [DM_SLOTS*AW-1:0] bundle,
                                                input int slot);
      return bundle[(DM_SLOTS-1-slot)*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] slot_data(input logic [DM_SLOTS*DW-1:0] bundle,
                                                input int slot);
      return bundle[(DM_SLOTS-1-slot)*DW +: DW];
   endfunction

endpackage

// File: rtl/rf_dup_mask.sv
// Keep-mask for a DM bundle: a slot is dropped when any later slot targets
// the same register, so the last writer of an address wins.
module rf_dup_mask
   import rf_arb_pkg::*;
(
   input  logic [DM_SLOTS*AW-1:0] slot_addrs,
   output logic [DM_SLOTS-1:0]    keep
);

   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path through the block can leave a latch behind.
      keep = '1;
      for (int i = 0; i < DM_SLOTS; i++) begin
         for (int j = i + 1; j < DM_SLOTS; j++) begin
            if (slot_addr(slot_addrs, i) == slot_addr(slot_addrs, j)) keep[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Sequences unit (M/A/S) and DM bundle writes onto the three RF write ports,
// never letting two ports hit the same register in one cycle.
module rf_write_arbiter
   import rf_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_M_valid,
   input  logic [AW-1:0]          req_M_addr,
   input  logic [DW-1:0]          req_M_data,
   output logic                   req_M_ready,
   input  logic                   req_A_valid,
   input  logic [AW-1:0]          req_A_addr,
   input  logic [DW-1:0]          req_A_data,
   output logic                   req_A_ready,
   input  logic                   req_S_valid,
   input  logic [AW-1:0]          req_S_addr,
   input  logic [DW-1:0]          req_S_data,
   output logic                   req_S_ready,
   input  logic                   dm_valid,
   input  logic [DM_SLOTS*AW-1:0] dm_addr,
   input  logic [DM_SLOTS*DW-1:0] dm_data,
   output logic                   dm_ready,
   output logic                   wen_w_M,
   output logic [AW-1:0]          addr_w_M,
   output logic [DW-1:0]          data_w_M,
   output logic                   wen_w_A,
   output logic [AW-1:0]          addr_w_A,
   output logic [DW-1:0]          data_w_A,
   output logic                   wen_w_S,
   output logic [AW-1:0]          addr_w_S,
   output logic [DW-1:0]          data_w_S,
   output logic                   busy
);

   logic [1:0]          state, state_n;
   logic                dm_turn, dm_turn_n;
   wr_port_t            port_m, port_a, port_s;
   wr_port_t            port_m_n, port_a_n, port_s_n;
   logic [DM_SLOTS-1:0] keep;
   logic                any_valid, dm_grant, unit_phase;
   logic                acc_m, acc_a, acc_s;

   rf_dup_mask u_dup_mask (
      .slot_addrs (dm_addr),
      .keep       (keep)
   );

   // DM wins when it holds the turn or when no unit is asking at all.
   assign any_valid  = req_M_valid | req_A_valid | req_S_valid;
   assign dm_grant   = (state == ST_IDLE) && dm_valid && (dm_turn || !any_valid);
   assign unit_phase = (state == ST_IDLE) && !dm_grant;

   // Conflicts look at valid only, so a stalled higher-priority request still blocks.
   assign req_S_ready = unit_phase;
   assign req_A_ready = unit_phase && !(req_S_valid && (req_S_addr == req_A_addr));
   assign req_M_ready = unit_phase && !(req_S_valid && (req_S_addr == req_M_addr))
                                   && !(req_A_valid && (req_A_addr == req_M_addr));

   assign acc_m = req_M_valid && req_M_ready;
   assign acc_a = req_A_valid && req_A_ready;
   assign acc_s = req_S_valid && req_S_ready;

   always_comb begin
      state_n      = state;
      dm_turn_n    = dm_turn;
      port_m_n     = port_m;
      port_a_n     = port_a;
      port_s_n     = port_s;
      port_m_n.wen = 1'b0;
      port_a_n.wen = 1'b0;
      port_s_n.wen = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dm_grant) state_n = ST_DM0;
            if (acc_m) port_m_n = '{1'b1, req_M_addr, req_M_data};
            if (acc_a) port_a_n = '{1'b1, req_A_addr, req_A_data};
            if (acc_s) port_s_n = '{1'b1, req_S_addr, req_S_data};
            if (acc_m || acc_a || acc_s) dm_turn_n = 1'b1;
         end
         ST_DM0: begin
            port_m_n = '{keep[PH0_SLOT_M], slot_addr(dm_addr, PH0_SLOT_M), slot_data(dm_data, PH0_SLOT_M)};
            port_a_n = '{keep[PH0_SLOT_A], slot_addr(dm_addr, PH0_SLOT_A), slot_data(dm_data, PH0_SLOT_A)};
            port_s_n = '{keep[PH0_SLOT_S], slot_addr(dm_addr, PH0_SLOT_S), slot_data(dm_data, PH0_SLOT_S)};
            state_n  = ST_DM1;
         end
         ST_DM1: begin
            port_m_n  = '{keep[PH1_SLOT_M], slot_addr(dm_addr, PH1_SLOT_M), slot_data(dm_data, PH1_SLOT_M)};
            port_a_n  = '{keep[PH1_SLOT_A], slot_addr(dm_addr, PH1_SLOT_A), slot_data(dm_data, PH1_SLOT_A)};
            dm_turn_n = 1'b0;
            state_n   = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      if (rst) begin
         state   <= ST_IDLE;
         dm_turn <= 1'b1;
         port_m  <= '0;
         port_a  <= '0;
         port_s  <= '0;
      end else begin
         state   <= state_n;
         dm_turn <= dm_turn_n;
         port_m  <= port_m_n;
         port_a  <= port_a_n;
         port_s  <= port_s_n;
      end
   end

   assign wen_w_M  = port_m.wen;
   assign addr_w_M = port_m.addr;
   assign data_w_M = port_m.data;
   assign wen_w_A  = port_a.wen;
   assign addr_w_A = port_a.addr;
   assign data_w_A = port_a.data;
   assign wen_w_S  = port_s.wen;
   assign addr_w_S = port_s.addr;
   assign data_w_S = port_s.data;

   // A reset landing in DM1 aborts the bundle, so completion is masked by rst.
   assign dm_ready = (state == ST_DM1) && !rst;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, directed corner
// sequences, and random traffic against a cycle-level behavioural model.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_M_valid = 1'b0, req_A_valid = 1'b0, req_S_valid = 1'b0;
   logic [3:0]  req_M_addr = '0, req_A_addr = '0, req_S_addr = '0;
   logic [15:0] req_M_data = '0, req_A_data = '0, req_S_data = '0;
   logic        req_M_ready, req_A_ready, req_S_ready;
   logic        dm_valid = 1'b0;
   logic [19:0] dm_addr = '0;
   logic [79:0] dm_data = '0;
   logic        dm_ready, busy;
   logic        wen_w_M, wen_w_A, wen_w_S;
   logic [3:0]  addr_w_M, addr_w_A, addr_w_S;
   logic [15:0] data_w_M, data_w_A, data_w_S;

   rf_write_arbiter dut (
      .clk(clk), .rst(rst),
      .req_M_valid(req_M_valid), .req_M_addr(req_M_addr), .req_M_data(req_M_data), .req_M_ready(req_M_ready),
      .req_A_valid(req_A_valid), .req_A_addr(req_A_addr), .req_A_data(req_A_data), .req_A_ready(req_A_ready),
      .req_S_valid(req_S_valid), .req_S_addr(req_S_addr), .req_S_data(req_S_data), .req_S_ready(req_S_ready),
      .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ready(dm_ready),
      .wen_w_M(wen_w_M), .addr_w_M(addr_w_M), .data_w_M(data_w_M),
      .wen_w_A(wen_w_A), .addr_w_A(addr_w_A), .data_w_A(data_w_A),
      .wen_w_S(wen_w_S), .addr_w_S(addr_w_S), .data_w_S(data_w_S),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dm_pulses = 0;
   int s_acc     = 0;
   logic last_dmr = 1'b0;

   // Model state: ph counts bundle progress (0 none, 1 first half due, 2 second half due).
   int          m_ph   = 0;
   bit          m_turn = 1'b1;
   logic [2:0]  e_wen  = '0;              // index 0=M, 1=A, 2=S
   logic [3:0]  e_addr [3];
   logic [15:0] e_data [3];
   logic [15:0] ref_rf [16];
   logic [15:0] dut_rf [16];
   string       pn [3] = '{"M", "A", "S"};

   typedef struct {
      logic       vs, va, vm;
      logic [3:0] as_, aa, am;
      logic       rs, ra, rm;
      logic       ws, wa, wm;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_port(input string name, input logic w, input logic [3:0] a, input logic [15:0] d,
                             input logic ew, input logic [3:0] ea, input logic [15:0] ed);
      if (ew) check(name, {11'd0, w, a, d}, {11'd0, 1'b1, ea, ed});
      else    check(name, {31'd0, w}, 32'd0);
   endtask

   task automatic compare_rf(input string name);
      int bad = 0;
      for (int i = 0; i < 16; i++) if (ref_rf[i] !== dut_rf[i]) bad++;
      check(name, bad, 0);
   endtask

   // Called at posedge+2 with this cycle's inputs settled; ends at the next posedge+1.
   task automatic eval(input bit do_check);
      logic [2:0]  v, rdy, n_wen;
      logic [3:0]  a [3];
      logic [15:0] d [3];
      logic [3:0]  n_addr [3];
      logic [15:0] n_data [3];
      logic        act_w [3];
      logic [3:0]  act_a [3];
      logic [15:0] act_d [3];
      bit grant, kept;
      v = {req_S_valid, req_A_valid, req_M_valid};
      a = '{req_M_addr, req_A_addr, req_S_addr};
      d = '{req_M_data, req_A_data, req_S_data};
      act_w = '{wen_w_M, wen_w_A, wen_w_S};
      act_a = '{addr_w_M, addr_w_A, addr_w_S};
      act_d = '{data_w_M, data_w_A, data_w_S};
      // Fixed priority S > A > M: blocked by any valid higher-priority request to the same register.
      for (int p = 0; p < 3; p++) begin
         rdy[p] = 1'b1;
         for (int q = p + 1; q < 3; q++) if (v[q] && a[q] == a[p]) rdy[p] = 1'b0;
      end
      grant = (m_ph == 0) && dm_valid && (m_turn || v == 3'b000);
      if (m_ph != 0 || grant) rdy = 3'b000;
      if (do_check) begin
         for (int p = 0; p < 3; p++)
            check_port({"model port ", pn[p]}, act_w[p], act_a[p], act_d[p], e_wen[p], e_addr[p], e_data[p]);
         check("model busy", {31'd0, busy}, {31'd0, m_ph != 0});
         check("model dm_ready", {31'd0, dm_ready}, {31'd0, (m_ph == 2) && !rst});
         if (!rst) check("model readies", {29'd0, req_S_ready, req_A_ready, req_M_ready}, {29'd0, rdy});
      end
      if (dm_ready === 1'b1) dm_pulses++;
      last_dmr = (dm_ready === 1'b1);
      if (req_S_valid === 1'b1 && req_S_ready === 1'b1) s_acc++;
      for (int p = 0; p < 3; p++) begin
         if (e_wen[p]) ref_rf[e_addr[p]] = e_data[p];
         if (act_w[p] === 1'b1) dut_rf[act_a[p]] = act_d[p];
      end
      n_wen  = 3'b000;
      n_addr = a;
      n_data = d;
      if (rst) begin
         m_ph   = 0;
         m_turn = 1'b1;
      end else if (m_ph == 0) begin
         if (grant) m_ph = 1;
         else begin
            n_wen = v & rdy;
            if (n_wen != 3'b000) m_turn = 1'b1;
         end
      end else begin
         for (int s = (m_ph == 1) ? 0 : 3; s < ((m_ph == 1) ? 3 : 5); s++) begin
            kept = 1'b1;
            for (int j = s + 1; j < 5; j++) if (dm_addr[(4-j)*4 +: 4] == dm_addr[(4-s)*4 +: 4]) kept = 1'b0;
            n_wen[s % 3]  = kept;
            n_addr[s % 3] = dm_addr[(4-s)*4 +: 4];
            n_data[s % 3] = dm_data[(4-s)*16 +: 16];
         end
         if (m_ph == 2) begin
            m_turn = 1'b0;
            m_ph   = 0;
         end else m_ph = 2;
      end
      e_wen  = n_wen;
      e_addr = n_addr;
      e_data = n_data;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      #1;
      eval(1'b1);
   endtask

   task automatic units_idle();
      req_M_valid = 1'b0;
      req_A_valid = 1'b0;
      req_S_valid = 1'b0;
   endtask

   initial begin
      int p0;
      for (int i = 0; i < 16; i++) begin
         ref_rf[i] = '0;
         dut_rf[i] = '0;
      end
      for (int p = 0; p < 3; p++) begin
         e_addr[p] = '0;
         e_data[p] = '0;
      end
      vecs[0] = '{0,0,0, 4'd1,4'd2,4'd3, 1,1,1, 0,0,0};
      vecs[1] = '{1,1,1, 4'd3,4'd3,4'd5, 1,0,1, 1,0,1};
      vecs[2] = '{0,1,1, 4'd3,4'd3,4'd3, 1,1,0, 0,1,0};
      vecs[3] = '{1,0,1, 4'd7,4'd7,4'd7, 1,0,0, 1,0,0};
      vecs[4] = '{1,1,1, 4'd1,4'd2,4'd3, 1,1,1, 1,1,1};
      vecs[5] = '{0,0,1, 4'd9,4'd9,4'd9, 1,1,1, 0,0,1};
      vecs[6] = '{1,1,1, 4'd4,4'd6,4'd6, 1,1,0, 1,1,0};
      vecs[7] = '{1,1,0, 4'd8,4'd2,4'd8, 1,1,0, 1,1,0};

      // Reset held two cycles, then idle state and open readies.
      @(posedge clk);
      #1;
      eval(1'b0);
      eval(1'b0);
      rst = 1'b0;
      #1;
      check("reset wen", {29'd0, wen_w_S, wen_w_A, wen_w_M}, 32'd0);
      check("reset addr", {20'd0, addr_w_S, addr_w_A, addr_w_M}, 32'd0);
      check("reset data M/A", {data_w_A, data_w_M}, 32'd0);
      check("reset data S", {16'd0, data_w_S}, 32'd0);
      check("reset dm_ready/busy", {30'd0, dm_ready, busy}, 32'd0);
      check("reset readies", {29'd0, req_S_ready, req_A_ready, req_M_ready}, 32'd7);
      eval(1'b1);

      // Vector table: readies this cycle, port writes one cycle later.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            {req_S_valid, req_A_valid, req_M_valid} = {vecs[i].vs, vecs[i].va, vecs[i].vm};
            {req_S_addr, req_A_addr, req_M_addr}    = {vecs[i].as_, vecs[i].aa, vecs[i].am};
            req_S_data = 16'h5000 + 16'(i);
            req_A_data = 16'h6000 + 16'(i);
            req_M_data = 16'h7000 + 16'(i);
         end else units_idle();
         #1;
         if (i < 8)
            check($sformatf("vec%0d readies", i), {29'd0, req_S_ready, req_A_ready, req_M_ready},
                  {29'd0, vecs[i].rs, vecs[i].ra, vecs[i].rm});
         if (i > 0) begin
            p0 = i - 1;
            check_port($sformatf("vec%0d port S", p0), wen_w_S, addr_w_S, data_w_S, vecs[p0].ws, vecs[p0].as_, 16'h5000 + 16'(p0));
            check_port($sformatf("vec%0d port A", p0), wen_w_A, addr_w_A, data_w_A, vecs[p0].wa, vecs[p0].aa, 16'h6000 + 16'(p0));
            check_port($sformatf("vec%0d port M", p0), wen_w_M, addr_w_M, data_w_M, vecs[p0].wm, vecs[p0].am, 16'h7000 + 16'(p0));
         end
         eval(1'b1);
      end

      // S and A collide on R3; A waits one cycle.
      req_S_valid = 1'b1; req_S_addr = 4'd3; req_S_data = 16'h1111;
      req_A_valid = 1'b1; req_A_addr = 4'd3; req_A_data = 16'h2222;
      req_M_valid = 1'b1; req_M_addr = 4'd5; req_M_data = 16'h5555;
      #1;
      check("conflict readies", {29'd0, req_S_ready, req_A_ready, req_M_ready}, 32'b101);
      eval(1'b1);
      req_S_valid = 1'b0;
      req_M_valid = 1'b0;
      #1;
      check("conflict A retry ready", {31'd0, req_A_ready}, 32'd1);
      check_port("conflict port S", wen_w_S, addr_w_S, data_w_S, 1'b1, 4'd3, 16'h1111);
      check_port("conflict port M", wen_w_M, addr_w_M, data_w_M, 1'b1, 4'd5, 16'h5555);
      check_port("conflict port A idle", wen_w_A, addr_w_A, data_w_A, 1'b0, 4'd0, 16'd0);
      eval(1'b1);
      units_idle();
      #1;
      check_port("conflict port A", wen_w_A, addr_w_A, data_w_A, 1'b1, 4'd3, 16'h2222);
      eval(1'b1);

      // Plain bundle: two phases, one dm_ready pulse.
      p0 = dm_pulses;
      dm_valid = 1'b1;
      dm_addr  = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      dm_data  = {16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E};
      #1;
      check("dm grant readies", {29'd0, req_S_ready, req_A_ready, req_M_ready}, 32'd0);
      check("dm grant busy", {31'd0, busy}, 32'd0);
      eval(1'b1);
      #1;
      check("dm0 busy/dm_ready", {30'd0, busy, dm_ready}, 32'b10);
      eval(1'b1);
      #1;
      check("dm1 busy/dm_ready", {30'd0, busy, dm_ready}, 32'b11);
      check_port("dm ph0 M", wen_w_M, addr_w_M, data_w_M, 1'b1, 4'd1, 16'h000A);
      check_port("dm ph0 A", wen_w_A, addr_w_A, data_w_A, 1'b1, 4'd2, 16'h000B);
      check_port("dm ph0 S", wen_w_S, addr_w_S, data_w_S, 1'b1, 4'd3, 16'h000C);
      eval(1'b1);
      dm_valid = 1'b0;
      #1;
      check("dm done busy/dm_ready", {30'd0, busy, dm_ready}, 32'd0);
      check_port("dm ph1 M", wen_w_M, addr_w_M, data_w_M, 1'b1, 4'd4, 16'h000D);
      check_port("dm ph1 A", wen_w_A, addr_w_A, data_w_A, 1'b1, 4'd5, 16'h000E);
      check_port("dm ph1 S", wen_w_S, addr_w_S, data_w_S, 1'b0, 4'd0, 16'd0);
      eval(1'b1);
      cyc();
      check("dm_ready pulse count", dm_pulses - p0, 1);

      // Duplicate addresses inside a bundle: later slot wins, across phases too.
      dm_valid = 1'b1;
      dm_addr  = {4'd7, 4'd2, 4'd7, 4'd9, 4'd2};
      dm_data  = {16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004};
      cyc();
      cyc();
      #1;
      check_port("dup ph0 M", wen_w_M, addr_w_M, data_w_M, 1'b0, 4'd0, 16'd0);
      check_port("dup ph0 A", wen_w_A, addr_w_A, data_w_A, 1'b0, 4'd0, 16'd0);
      check_port("dup ph0 S", wen_w_S, addr_w_S, data_w_S, 1'b1, 4'd7, 16'h4002);
      eval(1'b1);
      dm_valid = 1'b0;
      #1;
      check_port("dup ph1 M", wen_w_M, addr_w_M, data_w_M, 1'b1, 4'd9, 16'h4003);
      check_port("dup ph1 A", wen_w_A, addr_w_A, data_w_A, 1'b1, 4'd2, 16'h4004);
      eval(1'b1);
      check("dup R7", {16'd0, dut_rf[7]}, 32'h4002);
      check("dup R2", {16'd0, dut_rf[2]}, 32'h4004);

      // Continuous contention: S accept, bundle, S accept, bundle ...
      p0 = dm_pulses;
      s_acc = 0;
      dm_valid = 1'b1;
      dm_addr  = {4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
      dm_data  = {16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h3004};
      for (int k = 0; k < 12; k++) begin
         req_S_valid = 1'b1;
         req_S_addr  = 4'd4;
         req_S_data  = 16'h7000 + 16'(k);
         cyc();
      end
      dm_valid = 1'b0;
      units_idle();
      cyc();
      check("contention S accepts", s_acc, 3);
      check("contention bundles", dm_pulses - p0, 3);
      compare_rf("contention RF");

      // Reset during DM1 aborts the bundle; the reissue then completes.
      p0 = dm_pulses;
      dm_valid = 1'b1;
      dm_addr  = {4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
      dm_data  = {16'h6000, 16'h6001, 16'h6002, 16'h6003, 16'h6004};
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      check("rst in DM1 dm_ready", {31'd0, dm_ready}, 32'd0);
      eval(1'b1);
      rst = 1'b0;
      #1;
      check("after rst busy", {31'd0, busy}, 32'd0);
      check("after rst wen", {29'd0, wen_w_S, wen_w_A, wen_w_M}, 32'd0);
      eval(1'b1);
      cyc();
      #1;
      check("reissue dm_ready", {31'd0, dm_ready}, 32'd1);
      check_port("reissue ph0 S", wen_w_S, addr_w_S, data_w_S, 1'b1, 4'd12, 16'h6002);
      eval(1'b1);
      dm_valid = 1'b0;
      #1;
      check_port("reissue ph1 A", wen_w_A, addr_w_A, data_w_A, 1'b1, 4'd14, 16'h6004);
      eval(1'b1);
      check("reset-abort pulses", dm_pulses - p0, 1);

      // Random traffic against the model; bundles held until dm_ready.
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(63) == 0);
         req_M_valid = 1'($urandom_range(1));
         req_A_valid = 1'($urandom_range(1));
         req_S_valid = 1'($urandom_range(1));
         req_M_addr  = 4'($urandom_range(3));
         req_A_addr  = 4'($urandom_range(3));
         req_S_addr  = 4'($urandom_range(3));
         req_M_data  = 16'($urandom);
         req_A_data  = 16'($urandom);
         req_S_data  = 16'($urandom);
         if (dm_valid && last_dmr) dm_valid = 1'b0;
         else if (!dm_valid && $urandom_range(2) == 0) begin
            dm_valid = 1'b1;
            for (int s = 0; s < 5; s++) begin
               dm_addr[(4-s)*4 +: 4]   = 4'($urandom_range(7));
               dm_data[(4-s)*16 +: 16] = 16'($urandom);
            end
         end
         cyc();
      end
      rst = 1'b0;
      dm_valid = 1'b0;
      units_idle();
      cyc();
      cyc();
      cyc();
      compare_rf("random RF");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
